// File: rtl/push_button_event_engine_if.sv
// rtl/push_button_event_engine_if.sv - CPU slave and PIO master bus bundles for the push-button event engine
interface pbe_cpu_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, irq
    );
endinterface

interface pbe_pio_if;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        pio_irq;

    modport master (
        output pio_address, pio_chipselect, pio_write_n, pio_writedata,
        input  pio_readdata, pio_irq
    );

    modport slave (
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
        output pio_readdata, pio_irq
    );
endinterface

// File: rtl/push_button_event_engine.sv
// rtl/push_button_event_engine.sv - services PIO button interrupts into a timestamped event FIFO
module push_button_event_engine #(
    parameter logic [3:0] BUTTON_MASK    = 4'hF,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         HOLDOFF_CYCLES = 50000
) (
    input  logic   clk,
    input  logic   reset_n,
    pbe_cpu_if.slave  cpu,
    pbe_pio_if.master pio
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_EDGE,
        S_RD_LVL,
        S_CAP_LVL,
        S_CLR,
        S_PUSH,
        S_HOLDOFF
    } state_t;

    state_t state, state_next;

    logic [23:0]   ts;
    logic [23:0]   ev_ts;
    logic [3:0]    ev_edges;
    logic [3:0]    ev_level;
    logic [HW-1:0] hold_cnt;

    logic          enable;
    logic          overflow;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   readdata_q;
    logic [31:0]   rd_mux;

    logic [1:0]    m_addr_d, m_addr_q;
    logic          m_cs_d, m_cs_q;
    logic          m_wr_n_d, m_wr_n_q;
    logic [31:0]   m_wdata_d, m_wdata_q;

    logic cpu_rd, cpu_wr, pop, flush, push_req, do_push;
    logic unused_bits;

    assign cpu_rd   = cpu.chipselect && !cpu.read_n;
    assign cpu_wr   = cpu.chipselect && !cpu.write_n;
    assign pop      = cpu_rd && (cpu.address == 2'd0) && (count != '0);
    assign flush    = cpu_wr && (cpu.address == 2'd2) && cpu.writedata[1];
    assign push_req = (state == S_PUSH);
    // A full FIFO still accepts the push when a pop frees the head slot in the same cycle.
    assign do_push  = push_req && ((count != DEPTH_C) || pop);

    assign unused_bits = &{1'b0, cpu.writedata[31:2], pio.pio_readdata[31:4]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_INIT:    state_next = S_IDLE;
            S_IDLE:    if (pio.pio_irq && enable) state_next = S_RD_EDGE;
            S_RD_EDGE: state_next = S_RD_LVL;
            S_RD_LVL:  state_next = S_CAP_LVL;
            S_CAP_LVL: state_next = S_CLR;
            S_CLR:     state_next = S_PUSH;
            S_PUSH:    state_next = (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLDOFF;
            S_HOLDOFF: if (hold_cnt == '0) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Strobes are decoded from the upcoming state so each access is registered yet lines up
    // with its state; the mask write is the one exception and lands the cycle after INIT.
    always_comb begin
        m_cs_d    = 1'b0;
        m_wr_n_d  = 1'b1;
        m_addr_d  = 2'd0;
        m_wdata_d = 32'd0;
        if (state == S_INIT) begin
            m_cs_d    = 1'b1;
            m_wr_n_d  = 1'b0;
            m_addr_d  = 2'd2;
            m_wdata_d = {28'd0, BUTTON_MASK};
        end else begin
            case (state_next)
                S_RD_EDGE: begin
                    m_cs_d   = 1'b1;
                    m_addr_d = 2'd3;
                end
                S_RD_LVL: begin
                    m_cs_d   = 1'b1;
                    m_addr_d = 2'd0;
                end
                S_CLR: begin
                    m_cs_d   = 1'b1;
                    m_wr_n_d = 1'b0;
                    m_addr_d = 2'd3;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cs_q    <= 1'b0;
            m_wr_n_q  <= 1'b1;
            m_addr_q  <= 2'd0;
            m_wdata_q <= 32'd0;
            ts        <= 24'd0;
            ev_ts     <= 24'd0;
            ev_edges  <= 4'd0;
            ev_level  <= 4'd0;
            hold_cnt  <= '0;
        end else begin
            m_cs_q    <= m_cs_d;
            m_wr_n_q  <= m_wr_n_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            ts        <= ts + 24'd1;
            if (state == S_RD_EDGE) ev_ts    <= ts;
            if (state == S_RD_LVL)  ev_edges <= pio.pio_readdata[3:0];
            if (state == S_CAP_LVL) ev_level <= pio.pio_readdata[3:0];
            if (state == S_PUSH) begin
                hold_cnt <= HW'(HOLDOFF_CYCLES - 1);
            end else if ((state == S_HOLDOFF) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (cpu.address)
            2'd0:    if (count != '0) rd_mux = mem[rd_ptr];
            2'd1:    rd_mux = {overflow, 31'(count)};
            2'd2:    rd_mux = {31'd0, enable};
            default: rd_mux = 32'd0;
        endcase
    end

    // Flush overrides a simultaneous push or pop: the FIFO always ends empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable     <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            readdata_q <= 32'd0;
        end else begin
            readdata_q <= cpu_rd ? rd_mux : 32'd0;
            if (cpu_wr && (cpu.address == 2'd2)) enable <= cpu.writedata[0];
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(do_push) - CW'(pop);
                if (push_req && !do_push) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= {ev_ts, ev_level, ev_edges};
    end

    assign cpu.readdata       = readdata_q;
    assign cpu.irq            = enable && (count != '0);
    assign pio.pio_address    = m_addr_q;
    assign pio.pio_chipselect = m_cs_q;
    assign pio.pio_write_n    = m_wr_n_q;
    assign pio.pio_writedata  = m_wdata_q;

endmodule

// File: tb/tb_push_button_event_engine.sv
// tb/tb_push_button_event_engine.sv - directed bench with a PIO register model and bus monitor
module tb_push_button_event_engine;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pbe_cpu_if cpu ();
    pbe_pio_if pio ();

    push_button_event_engine #(
        .BUTTON_MASK   (4'hF),
        .FIFO_DEPTH    (4),
        .HOLDOFF_CYCLES(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .cpu    (cpu),
        .pio    (pio)
    );

    // PIO model: rising-edge capture, any write to address 3 clears all captured edges
    logic [3:0]  in_port = 4'd0;
    logic [3:0]  in_d, edge_cap, irq_mask;
    logic [31:0] pio_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_d     <= 4'd0;
            edge_cap <= 4'd0;
            irq_mask <= 4'd0;
            pio_rd   <= 32'd0;
        end else begin
            in_d <= in_port;
            case (pio.pio_address)
                2'd0:    pio_rd <= {28'd0, in_port};
                2'd2:    pio_rd <= {28'd0, irq_mask};
                2'd3:    pio_rd <= {28'd0, edge_cap};
                default: pio_rd <= 32'd0;
            endcase
            if (pio.pio_chipselect && !pio.pio_write_n) begin
                if (pio.pio_address == 2'd2) irq_mask <= pio.pio_writedata[3:0];
                if (pio.pio_address == 2'd3) edge_cap <= 4'd0;
            end else begin
                edge_cap <= edge_cap | (in_port & ~in_d);
            end
        end
    end

    assign pio.pio_readdata = pio_rd;
    assign pio.pio_irq      = |(edge_cap & irq_mask);

    logic [23:0] ts_model;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts_model <= 24'd0;
        else          ts_model <= ts_model + 24'd1;
    end

    // Bus monitor: builds the event each serviced interrupt should produce
    logic [31:0] ev_words  [64];
    logic [23:0] ev_rd_ts  [64];
    logic [23:0] ev_clr_ts [64];
    logic [23:0] cur_ts;
    logic [3:0]  cur_edges, cur_level;
    int ev_n   = 0;
    int init_n = 0;

    always @(negedge clk) begin
        if (reset_n && pio.pio_chipselect) begin
            if (pio.pio_write_n && pio.pio_address == 2'd3) begin
                cur_ts    = ts_model;
                cur_edges = edge_cap;
            end else if (pio.pio_write_n && pio.pio_address == 2'd0) begin
                cur_level = in_port;
            end else if (!pio.pio_write_n && pio.pio_address == 2'd3 && ev_n < 64) begin
                ev_words[ev_n]  = {cur_ts, cur_level, cur_edges};
                ev_rd_ts[ev_n]  = cur_ts;
                ev_clr_ts[ev_n] = ts_model;
                ev_n++;
            end else if (!pio.pio_write_n && pio.pio_address == 2'd2) begin
                init_n++;
            end
        end
    end

    int pass_n  = 0;
    int total_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk);
        #1 cpu.chipselect = 1'b1; cpu.read_n = 1'b0; cpu.address = a;
        @(posedge clk);
        #1 cpu.chipselect = 1'b0; cpu.read_n = 1'b1;
        d = cpu.readdata;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1 cpu.chipselect = 1'b1; cpu.write_n = 1'b0; cpu.address = a; cpu.writedata = wd;
        @(posedge clk);
        #1 cpu.chipselect = 1'b0; cpu.write_n = 1'b1; cpu.writedata = 32'd0;
    endtask

    task automatic press(input logic [3:0] v, input int n);
        @(posedge clk);
        #1 in_port = v;
        repeat (n) @(posedge clk);
        #1 in_port = 4'd0;
    endtask

    task automatic wait_event(input int n0);
        int k = 0;
        while (ev_n == n0 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("event_seen", 32'(ev_n != n0), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_readdata"}, cpu.readdata, 32'd0);
        check({tag, "_irq"}, 32'(cpu.irq), 32'd0);
        check({tag, "_pio_address"}, 32'(pio.pio_address), 32'd0);
        check({tag, "_pio_cs"}, 32'(pio.pio_chipselect), 32'd0);
        check({tag, "_pio_write_n"}, 32'(pio.pio_write_n), 32'd1);
        check({tag, "_pio_wdata"}, pio.pio_writedata, 32'd0);
    endtask

    task automatic check_init_write(input string tag);
        check({tag, "_cs"}, 32'(pio.pio_chipselect), 32'd1);
        check({tag, "_write_n"}, 32'(pio.pio_write_n), 32'd0);
        check({tag, "_addr"}, 32'(pio.pio_address), 32'd2);
        check({tag, "_wdata"}, pio.pio_writedata, 32'h0000_000F);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int n0, m0, i0;
        logic [23:0] t_irq;

        vecs[0]  = '{2'd1, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[1]  = '{2'd2, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[2]  = '{2'd0, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[3]  = '{2'd3, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[4]  = '{2'd3, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[5]  = '{2'd3, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[6]  = '{2'd2, 1'b1, 32'h3,        32'h0, 1'b0};
        vecs[7]  = '{2'd2, 1'b0, 32'h0,        32'h1, 1'b0};
        vecs[8]  = '{2'd1, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[9]  = '{2'd2, 1'b1, 32'h0,        32'h0, 1'b0};
        vecs[10] = '{2'd2, 1'b0, 32'h0,        32'h0, 1'b0};

        cpu.chipselect = 1'b0;
        cpu.read_n     = 1'b1;
        cpu.write_n    = 1'b1;
        cpu.address    = 2'd0;
        cpu.writedata  = 32'd0;

        tick(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick(1);
        check_init_write("init");
        tick(1);
        check("init_idle_cs", 32'(pio.pio_chipselect), 32'd0);
        tick(4);
        check("init_write_count", 32'(init_n), 32'd1);
        check("init_mask_in_pio", 32'(irq_mask), 32'hF);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) begin
                cpu_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                cpu_read(vecs[i].addr, rd);
                check($sformatf("table_rd[%0d]", i), rd, vecs[i].exp_rd);
            end
            check($sformatf("table_irq[%0d]", i), 32'(cpu.irq), 32'(vecs[i].exp_irq));
        end

        // Disabled engine leaves the PIO interrupt pending; enabling services it
        n0 = ev_n;
        press(4'b0010, 3);
        tick(20);
        check("disabled_no_event", 32'(ev_n), 32'(n0));
        check("disabled_pio_irq_pending", 32'(pio.pio_irq), 32'd1);
        cpu_write(2'd2, 32'h1);
        wait_event(n0);
        tick(8);
        cpu_read(2'd1, rd);
        check("enabled_status", rd, 32'h1);
        check("enabled_irq", 32'(cpu.irq), 32'd1);
        cpu_read(2'd0, rd);
        check("enabled_event", rd, ev_words[n0]);
        check("enabled_edges", 32'(rd[3:0]), 32'h2);
        check("enabled_level", 32'(rd[7:4]), 32'h0);

        // Button 2 pulse with cycle-exact latency checks
        n0 = ev_n;
        @(posedge clk);
        #1 in_port = 4'b0100;
        @(posedge clk);
        #1 t_irq = ts_model;
        tick(1);
        @(posedge clk);
        #1 in_port = 4'b0000;
        wait_event(n0);
        check("pulse_clr_spacing", 32'(ev_clr_ts[n0] - ev_rd_ts[n0]), 32'd3);
        @(negedge clk);
        #1;
        check("pulse_edgecap_cleared", 32'(edge_cap), 32'd0);
        check("pulse_irq_in_push", 32'(cpu.irq), 32'd0);
        @(negedge clk);
        #1;
        check("pulse_irq_after_push", 32'(cpu.irq), 32'd1);
        cpu_read(2'd1, rd);
        check("pulse_status_1", rd, 32'h1);
        cpu_read(2'd0, rd);
        check("pulse_event", rd, ev_words[n0]);
        check("pulse_edges", 32'(rd[3:0]), 32'h4);
        check("pulse_ts", 32'(rd[31:8]), 32'(t_irq + 24'd1));
        cpu_read(2'd1, rd);
        check("pulse_status_0", rd, 32'h0);
        check("pulse_irq_low", 32'(cpu.irq), 32'd0);
        tick(8);

        // Bounce: five presses one cycle apart collapse into two events
        n0 = ev_n;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 in_port = (i % 2 == 0) ? 4'b0001 : 4'b0000;
        end
        tick(40);
        check("bounce_event_count", 32'(ev_n - n0), 32'd2);
        cpu_read(2'd1, rd);
        check("bounce_status", rd, 32'h2);
        cpu_read(2'd0, rd);
        check("bounce_ev0", rd, ev_words[n0]);
        check("bounce_ev0_edges", 32'(rd[3:0]), 32'h1);
        i0 = int'(rd[31:8]);
        cpu_read(2'd0, rd);
        check("bounce_ev1", rd, ev_words[n0 + 1]);
        check("bounce_ev1_edges", 32'(rd[3:0]), 32'h1);
        check("bounce_holdoff_gap", 32'(int'(rd[31:8]) - i0), 32'd10);

        // Overflow: fifth event dropped, flush clears count and overflow
        n0 = ev_n;
        for (int i = 0; i < 5; i++) begin
            press(4'(1 << (i % 4)), 2);
            wait_event(n0 + i);
            tick(8);
        end
        cpu_read(2'd1, rd);
        check("ovf_status", rd, 32'h8000_0004);
        cpu_read(2'd0, rd);
        check("ovf_oldest_kept", rd, ev_words[n0]);
        cpu_read(2'd1, rd);
        check("ovf_status_after_pop", rd, 32'h8000_0003);
        cpu_write(2'd2, 32'h3);
        cpu_read(2'd1, rd);
        check("flush_status", rd, 32'h0);
        check("flush_irq", 32'(cpu.irq), 32'd0);
        cpu_read(2'd2, rd);
        check("flush_control", rd, 32'h1);

        cpu_read(2'd0, rd);
        check("empty_event_read", rd, 32'h0);
        cpu_read(2'd1, rd);
        check("empty_status", rd, 32'h0);

        // Pop in the same cycle as PUSH while full: both succeed
        m0 = ev_n;
        for (int i = 0; i < 4; i++) begin
            press(4'(1 << i), 2);
            wait_event(m0 + i);
            tick(8);
        end
        cpu_read(2'd1, rd);
        check("full_status", rd, 32'h4);
        press(4'b1000, 2);
        wait_event(m0 + 4);
        cpu_read(2'd0, rd);
        check("full_pop_with_push", rd, ev_words[m0]);
        cpu_read(2'd1, rd);
        check("full_push_pop_status", rd, 32'h4);
        for (int j = 0; j < 4; j++) begin
            cpu_read(2'd0, rd);
            check($sformatf("full_drain[%0d]", j), rd, ev_words[m0 + 1 + j]);
        end
        cpu_read(2'd1, rd);
        check("full_drained_status", rd, 32'h0);
        tick(8);

        // Reset asserted while the engine is in CLR
        n0 = ev_n;
        press(4'b0001, 2);
        wait_event(n0);
        tick(8);
        check("pre_reset_irq", 32'(cpu.irq), 32'd1);
        press(4'b0010, 2);
        wait_event(n0 + 1);
        check("clr_strobe_before_reset", 32'(pio.pio_write_n), 32'd0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick(2);
        reset_n = 1'b1;
        i0 = init_n;
        tick(1);
        check_init_write("reinit");
        tick(3);
        check("reinit_write_count", 32'(init_n - i0), 32'd1);
        cpu_read(2'd2, rd);
        check("reinit_control", rd, 32'h0);
        cpu_read(2'd1, rd);
        check("reinit_status", rd, 32'h0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
